tick_period_meter: RTL

Measures the period, in `clk` cycles, of an incoming tick/pulse train: the inverse of the block's clock-divider tick generators. Each rising edge on `tick_in` closes one measurement, and the result is delivered on a valid/ready output. The block sits beside the divider chain in the microwave controller, where it checks divider ratios in-system and measures externally supplied timing pulses.

---
 rtl/tick_period_meter_if.sv | 28 ++
 rtl/tick_period_meter.sv | 115 +++++++++++
 2 files changed

// File: rtl/tick_period_meter_if.sv
// Result channel of the tick period meter:
// valid/ready handshake plus status flags.
`timescale 1ns/1ps
interface tick_period_meter_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] period_out;
    logic             period_valid;
    logic             period_ready;
    logic             timeout;
    logic             overrun;

    modport master (
        output period_out,
        output period_valid,
        output timeout,
        output overrun,
        input  period_ready
    );

    modport slave (
        input  period_out,
        input  period_valid,
        input  timeout,
        input  overrun,
        output period_ready
    );
endinterface

// File: rtl/tick_period_meter.sv
// Tick period meter: counts clk cycles between
// rising edges of an asynchronous pulse train.
`timescale 1ns/1ps
module tick_period_meter #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick_in,
    input  logic                 meas_en,
    tick_period_meter_if.master  res
);
    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEAS
    } state_t;

    localparam logic [WIDTH-1:0] CMAX = '1;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    state_t                 r_state;
    logic [WIDTH-1:0]       r_cnt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic [SYNC_STAGES:0]   r_vld;
    logic                   r_edge;
    logic                   w_edge;
    logic                   w_cap;

    // r_vld marks stages holding a real post-reset
    // sample, so a level already high at reset
    // release is never mistaken for an edge.
    assign w_edge = r_sync[SYNC_STAGES-1] & ~r_hist
                  & r_vld[SYNC_STAGES];

    assign w_cap = (r_state == MEAS) & r_edge;

    // Synchronizer, history flop and registered edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_hist <= 1'b0;
            r_vld  <= '0;
            r_edge <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], tick_in};
            r_hist <= r_sync[SYNC_STAGES-1];
            r_vld  <= {r_vld[SYNC_STAGES-1:0], 1'b1};
            r_edge <= w_edge;
        end
    end

    // Measurement FSM, counter and result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= IDLE;
            r_cnt            <= '0;
            res.period_out   <= '0;
            res.period_valid <= 1'b0;
            res.timeout      <= 1'b0;
            res.overrun      <= 1'b0;
        end else begin
            res.timeout <= 1'b0;
            if (!meas_en) begin
                r_state          <= IDLE;
                r_cnt            <= '0;
                res.period_out   <= '0;
                res.period_valid <= 1'b0;
                res.overrun      <= 1'b0;
            end else begin
                unique case (r_state)
                    IDLE: begin
                        r_state <= ARM;
                    end
                    ARM: begin
                        if (r_edge) begin
                            r_cnt   <= ONE;
                            r_state <= MEAS;
                        end
                    end
                    MEAS: begin
                        if (r_edge) begin
                            r_cnt <= ONE;
                        end else if (r_cnt != CMAX) begin
                            r_cnt <= r_cnt + ONE;
                        end else begin
                            res.timeout <= 1'b1;
                            r_cnt       <= '0;
                            r_state     <= ARM;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase

                if (w_cap) begin
                    if (!res.period_valid) begin
                        res.period_out   <= r_cnt;
                        res.period_valid <= 1'b1;
                    end else if (res.period_ready) begin
                        res.period_out <= r_cnt;
                    end else begin
                        res.overrun <= 1'b1;
                    end
                end else if (res.period_valid &&
                             res.period_ready) begin
                    res.period_valid <= 1'b0;
                end
            end
        end
    end
endmodule
